// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, queue entry
// layout and the address range check used on both sequential and redirect PCs.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word index compare, done before pc+4 can wrap past the top of memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order queue of fetched {pc, instr} entries; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the combinational instruction
// memory and feeds decode through an in-order queue with redirect/halt/fault.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic        busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_redir;
  logic             w_redir_bad;
  logic             w_pc_bad;
  logic             w_out_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;

  assign w_redir      = redirect_valid && (r_state != FAULT);
  assign w_redir_bad  = (redirect_pc[1:0] != 2'b00) || !addr_in_range(redirect_pc, 32'(MEM_WORDS));
  assign w_pc_bad     = !addr_in_range(r_pc, 32'(MEM_WORDS));
  assign w_out_valid  = (w_count != '0);
  assign w_pop        = w_out_valid && out_ready;
  assign w_push       = (r_state == RUN) && !w_redir && !halt && !w_pc_bad &&
                        ((w_count < CNT_W'(DEPTH)) || w_pop);
  assign w_push_entry = '{pc: r_pc, instr: imem_rdata};
  // Entering or sitting in FAULT keeps the queue empty, as does any redirect.
  assign w_flush      = w_redir || (w_state_nxt == FAULT) || (r_state == FAULT);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_redir) begin
      if (w_redir_bad) begin
        w_state_nxt = FAULT;
      end else begin
        w_pc_nxt = redirect_pc;
        if (r_state == BOOT) w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        BOOT:    w_state_nxt = addr_in_range(RESET_PC, 32'(MEM_WORDS)) ? RUN : FAULT;
        RUN: begin
          if (w_pc_bad)  w_state_nxt = FAULT;
          else if (halt) w_state_nxt = HALTED;
        end
        HALTED:  if (!halt) w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
      if (w_push) w_pc_nxt = r_pc + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_addr = r_pc;
  assign out_valid = w_out_valid;
  assign out_instr = w_out_valid ? w_head.instr : 32'h0;
  assign out_pc    = w_out_valid ? w_head.pc    : 32'h0;
  assign fault     = (r_state == FAULT);
  assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against a queue-based behavioural model.
module tb_imem_fetch_ctrl;

  localparam int          MEM_WORDS = 32;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam int S_BOOT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_HALT  = 2;
  localparam int S_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic        busy;

  logic [31:0] mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  int          m_st;
  logic [31:0] m_pc;
  logic [63:0] m_q [$];

  imem_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr[31:2] < 30'(MEM_WORDS)) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 2) < 32'(MEM_WORDS);
  endfunction

  // Reference: queue of {pc, instr}; one call advances one clock edge.
  task automatic model_step();
    logic popped;
    popped = (m_q.size() != 0) && out_ready;
    if (m_st != S_FAULT) begin
      if (redirect_valid) begin
        m_q.delete();
        if (redirect_pc[1:0] != 2'b00 || !in_range(redirect_pc)) begin
          m_st = S_FAULT;
        end else begin
          m_pc = redirect_pc;
          if (m_st == S_BOOT) m_st = S_RUN;
        end
      end else begin
        if (popped) void'(m_q.pop_front());
        case (m_st)
          S_BOOT: m_st = in_range(RESET_PC) ? S_RUN : S_FAULT;
          S_RUN: begin
            if (!in_range(m_pc)) begin
              m_st = S_FAULT;
              m_q.delete();
            end else if (halt) begin
              m_st = S_HALT;
            end else if (m_q.size() < DEPTH) begin
              m_q.push_back({m_pc, mem[m_pc[6:2]]});
              m_pc = m_pc + 32'd4;
            end
          end
          S_HALT: if (!halt) m_st = S_RUN;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [98:0] exp_vec();
    logic [63:0] h;
    h = 64'h0;
    if (m_q.size() != 0) h = m_q[0];
    return {(m_q.size() != 0), h, m_pc, (m_st == S_FAULT), (m_st == S_RUN)};
  endfunction

  function automatic logic [98:0] dut_vec();
    return {out_valid, out_pc, out_instr, imem_addr, fault, busy};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    m_st = S_BOOT;
    m_pc = RESET_PC;
    m_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h want 0/0/0", out_valid, out_instr, out_pc);
    end
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_ctl: fault=%b busy=%b addr=%h want 0/0/%h", fault, busy, imem_addr, RESET_PC);
    end
    apply_reset();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL boot_latency: valid=%b busy=%b want 0/1", out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'(32'h100 + i)) begin
        errors++;
        $display("FAIL first_heads[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    apply_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_model: dut=%h model=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (imem_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100) begin
      errors++;
      $display("FAIL bp_hold: addr=%h valid=%b pc=%h instr=%h want 8/1/0/100",
               imem_addr, out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'(32'h100 + i)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h want 0/40", out_valid, imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h110) begin
      errors++;
      $display("FAIL redir_head: valid=%b pc=%h instr=%h want 1/40/110", out_valid, out_pc, out_instr);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid === 1'b1 && out_pc < 32'h40) begin
        errors++;
        $display("FAIL redir_stale: pc=%h want >= 40", out_pc);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL redir_model: dut=%h model=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fault_redirect();
    logic [31:0] frozen;
    frozen = m_pc;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== frozen) begin
      errors++;
      $display("FAIL fault_misalign: fault=%b busy=%b valid=%b addr=%h want 1/0/0/%h",
               fault, busy, out_valid, imem_addr, frozen);
    end
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      redirect_valid = (i == 1);
      redirect_pc = 32'h20;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fault_model: dut=%h model=%h", dut_vec(), exp_vec());
      end
    end
    redirect_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: fault=%b addr=%h valid=%b want 0/%h/0", fault, imem_addr, out_valid, RESET_PC);
    end
  endtask

  task automatic test_end_of_mem();
    logic saw_7c;
    logic saw_80;
    logic done;
    saw_7c = 1'b0;
    saw_80 = 1'b0;
    done = 1'b0;
    out_ready = 1'b1;
    apply_reset();
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL eom_model: dut=%h model=%h", dut_vec(), exp_vec());
      end
      if (out_valid === 1'b1 && out_pc === 32'h7C) saw_7c = 1'b1;
      if (out_valid === 1'b1 && out_pc === 32'h80) saw_80 = 1'b1;
      if (fault === 1'b1) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL eom_fault: fault_seen=%b addr=%h want 1/80", done, imem_addr);
    end
    checks++;
    if (saw_7c !== 1'b1 || saw_80 !== 1'b0) begin
      errors++;
      $display("FAIL eom_last: saw7c=%b saw80=%b want 1/0", saw_7c, saw_80);
    end
  endtask

  task automatic test_halt();
    logic [31:0] pc_hold;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    pc_hold = m_pc;
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL halt_model: dut=%h model=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== pc_hold || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_drain: valid=%b addr=%h busy=%b want 0/%h/0", out_valid, imem_addr, busy, pc_hold);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h10 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_redir: addr=%h busy=%b valid=%b want 10/0/0", imem_addr, busy, out_valid);
    end
    halt = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h104) begin
      errors++;
      $display("FAIL halt_resume: valid=%b pc=%h instr=%h want 1/10/104", out_valid, out_pc, out_instr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_model[%0d]: dut=%h model=%h", n, dut_vec(), exp_vec());
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_range_fault: fault=%b valid=%b want 1/0", fault, out_valid);
    end
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rand_fault_model: dut=%h model=%h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h100 + 32'(i);
    m_st = S_BOOT;
    m_pc = RESET_PC;
    test_reset();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_end_of_mem();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
